muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes rs1_data/rs2_data and the destination register index; produces a result plus a one-cycle done strobe that drives the register-file write port (rd_data, rd, write_enable).
- Pipeline control stalls issue while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried through the unit.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request; accepted only when ready=1
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand A (multiplicand/dividend)
- rs2_data  input  XLEN  operand B (multiplier/divisor)
- rd_in  input  TAG_W  destination register tag
- flush  input  1  abort in-flight op
- ready  output  1  unit can accept start this cycle
- busy  output  1  op in progress, stall issue
- done  output  1  result valid, one-cycle pulse; used as write_enable
- result  output  XLEN  op result, held until next accepted start
- rd_out  output  TAG_W  tag of completed op

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, busy=0, done=0, result=0, rd_out=0, internal operand/accumulator registers=0. Applies immediately, including mid-operation; no done is produced for the aborted op.
- States: IDLE, CALC, FIX, DONE.
- ready=1 in IDLE and DONE. busy=1 in CALC and FIX. done=1 only in DONE.
- Accept: start=1 with ready=1 at edge k. Latch funct3, rd_in, and absolute-value operands per signedness; record result sign. start with ready=0 is ignored and has no side effects.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV and REM: signed.
- Fast path (from accept edge k directly to DONE at edge k, done visible after edge k):
  - Divide by zero (rs2=0): DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1_data.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV result=0x80000000, REM result=0.
- Normal path:
  - State CALC at edge k, counter=0.
  - Edges k+1..k+32: one iteration each. Multiply is radix-2 shift-add into a 64-bit accumulator. Divide is restoring, one quotient bit per edge, with a 33-bit partial remainder.
  - The counter wraps 31->0 on the edge where it moves CALC->FIX, at edge k+32.
  - Edge k+33: FIX applies sign correction (two's-complement negate of the 64-bit product, the quotient, or the remainder as recorded); register result and rd_out; state->DONE.
  - done is high for exactly one cycle after edge k+33.
- Result selection:
  - MUL: low 32 bits of product. MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient, rounds toward zero. REM/REMU: remainder, sign follows dividend.
- DONE: next edge goes to IDLE, unless start=1, which is accepted (back-to-back issue, no bubble).
- flush=1 in CALC or FIX: state->IDLE at next edge, no done, result unchanged. flush in DONE: done still completes this cycle. flush has priority over start in the same cycle; start is dropped.
- rd_out=0 still produces done; the register file ignores writes to x0.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MUL* ops use a single combinational 33x33 signed multiplier on the latched sign-extended operands. Accept edge k -> CALC; edge k+1 -> DONE with result. done is visible after edge k+1; FIX is skipped. Division is unchanged.
- Undefined: all multiplies use the 32-iteration path, latency 33 edges; no hardware multiplier is inferred.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly one cycle, first high after edge k+33 (k+1 with MULDIV_FAST_MUL_EN); busy high edges k..k+32.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. rd_out equals issued rd_in=13.
- DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All fast paths: done after edge k, busy never asserted.
- flush at 10th CALC edge -> IDLE next edge, no done, result holds previous value. rst_n low mid-CALC -> all outputs 0 immediately. A following start completes correctly.
- start while busy -> ignored, result matches first op. start during DONE cycle -> accepted, second done 34 edges later, no idle cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Optional MULDIV_FAST_MUL_EN replaces the multiply iterations with one 33x33 signed multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [TAG_W-1:0]  r_rdOut;
  logic [TAG_W-1:0]  r_tag;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_b;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] r_sa;
  logic signed [XLEN:0] r_sb;
`else
  logic [XLEN-1:0]   r_a;
`endif

  logic            w_isDiv;
  logic            w_aSigned;
  logic            w_bSigned;
  logic            w_negA;
  logic            w_negB;
  logic            w_divZero;
  logic            w_ovf;
  logic            w_accept;
  logic [XLEN-1:0] w_absA;
  logic [XLEN-1:0] w_absB;
  logic [XLEN-1:0] w_fastRes;

  assign w_isDiv   = funct3[2];
  assign w_aSigned = w_isDiv ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_bSigned = w_isDiv ? ~funct3[0] : ~funct3[1];
  assign w_negA    = w_aSigned & rs1_data[XLEN-1];
  assign w_negB    = w_bSigned & rs2_data[XLEN-1];
  assign w_absA    = w_negA ? -rs1_data : rs1_data;
  assign w_absB    = w_negB ? -rs2_data : rs2_data;
  assign w_divZero = w_isDiv && (rs2_data == '0);
  assign w_ovf     = w_isDiv && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == '1);
  // Both special cases return rs1 for one of the two op kinds, so it doubles as the overflow quotient.
  assign w_fastRes = funct3[1] ? (w_divZero ? rs1_data : '0) : (w_divZero ? '1 : rs1_data);
  assign w_accept  = start && ready && !flush;

`ifndef MULDIV_FAST_MUL_EN
  logic [XLEN:0] w_mSum;
  assign w_mSum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_a : '0)};
`endif

  // Remainder after each step is below the divisor, so the low XLEN bits of the difference are exact.
  logic [XLEN:0]   w_partial;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  assign w_partial = {r_rem, r_acc[XLEN-1]};
  assign w_ge      = w_partial >= {1'b0, r_b};
  assign w_diff    = w_partial[XLEN-1:0] - r_b;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_fixRes;
  assign w_prod   = r_neg ? -r_acc : r_acc;
  assign w_quo    = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_remFix = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_fixRes = w_prod[XLEN-1:0];
    case (r_op)
      3'b000:                 w_fixRes = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fixRes = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fixRes = w_quo;
      default:                w_fixRes = w_remFix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fprod;
  logic [XLEN-1:0]          w_fastMulRes;
  assign w_fprod      = r_sa * r_sb;
  assign w_fastMulRes = (r_op[1:0] == 2'b00) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rdOut  <= '0;
      r_tag    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_b      <= '0;
`ifdef MULDIV_FAST_MUL_EN
      r_sa     <= '0;
      r_sb     <= '0;
`else
      r_a      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            r_op  <= funct3;
            r_tag <= rd_in;
            // Remainder takes the dividend's sign; products and quotients take the XOR.
            r_neg <= (w_isDiv && funct3[1]) ? w_negA : (w_negA ^ w_negB);
            r_b   <= w_absB;
            r_rem <= '0;
            r_acc <= {{XLEN{1'b0}}, (w_isDiv ? w_absA : w_absB)};
            r_cnt <= '0;
`ifdef MULDIV_FAST_MUL_EN
            r_sa  <= {w_aSigned & rs1_data[XLEN-1], rs1_data};
            r_sb  <= {w_bSigned & rs2_data[XLEN-1], rs2_data};
`else
            r_a   <= w_absA;
`endif
            if (w_divZero || w_ovf) begin
              r_state  <= S_DONE;
              r_result <= w_fastRes;
              r_rdOut  <= rd_in;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!r_op[2]) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_fastMulRes;
            r_rdOut  <= r_tag;
          end
`endif
          else begin
            if (r_op[2]) begin
              r_rem <= w_ge ? w_diff : w_partial[XLEN-1:0];
              r_acc <= {{XLEN{1'b0}}, r_acc[XLEN-2:0], w_ge};
            end
`ifndef MULDIV_FAST_MUL_EN
            else begin
              r_acc <= {w_mSum, r_acc[XLEN-1:1]};
            end
`endif
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(XLEN-1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_fixRes;
            r_rdOut  <= r_tag;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready  = ~r_busy;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rdOut;

endmodule
